// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: NUM_SERVOS-channel servo PWM generator driven from one shared frame counter
// Ports: clk; ResetServoModule (async, active-high); EnableServos runs frames;
//   ServoNum/ActiveServoDuty select the servo and its high time in clk cycles;
//   ServoPWM one line per servo; ActivePeriodFinished one-cycle pulse per frame boundary;
//   DutyClampHit sticky saturation flag.
// Build option: define SERVO_CLAMP_EN to saturate sampled duties to [MIN_DUTY, MAX_DUTY].
module servo_pwm_driver #(
  parameter int PERIOD_CYCLES = 2_000_000,
  parameter int NUM_SERVOS    = 4,
  parameter int DUTY_W        = 21,
  parameter int PARK_DUTY     = 100_000,
  parameter int MIN_DUTY      = 50_000,
  parameter int MAX_DUTY      = 250_000
) (
  input  logic                  clk,
  input  logic                  ResetServoModule,
  input  logic                  EnableServos,
  input  logic [1:0]            ServoNum,
  input  logic [DUTY_W-1:0]     ActiveServoDuty,
  output logic [NUM_SERVOS-1:0] ServoPWM,
  output logic                  ActivePeriodFinished,
  output logic                  DutyClampHit
);
`ifdef SERVO_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [DUTY_W-1:0] counter, counter_d, duty_in;
  logic [DUTY_W-1:0] duty_reg [NUM_SERVOS];
  logic [NUM_SERVOS-1:0] pwm_d;
  logic wrap, sample, lo, hi, apf_d;
  always_ff @(posedge clk or posedge ResetServoModule)
    if (ResetServoModule) state <= IDLE;
    else state <= state_d;
  always_comb state_d = EnableServos ? RUN : IDLE;
  // A falling enable overrides the wrap: no sample, no frame pulse, pulse truncated.
  always_comb begin
    wrap = state == RUN && counter == DUTY_W'(PERIOD_CYCLES - 1);
    sample = EnableServos && (state == IDLE || wrap) && int'(ServoNum) < NUM_SERVOS;
    lo = CLAMP && ActiveServoDuty < DUTY_W'(MIN_DUTY);
    hi = CLAMP && ActiveServoDuty > DUTY_W'(MAX_DUTY);
    duty_in = lo ? DUTY_W'(MIN_DUTY) : hi ? DUTY_W'(MAX_DUTY) : ActiveServoDuty;
    counter_d = (state == RUN && EnableServos && !wrap) ? counter + DUTY_W'(1) : '0;
    apf_d = EnableServos && wrap;
    for (int i = 0; i < NUM_SERVOS; i++)
      pwm_d[i] = state == RUN && EnableServos && counter < duty_reg[i];
  end
  always_ff @(posedge clk or posedge ResetServoModule)
    if (ResetServoModule) begin
      counter <= '0;
      ServoPWM <= '0;
      ActivePeriodFinished <= 1'b0;
      DutyClampHit <= 1'b0;
      for (int i = 0; i < NUM_SERVOS; i++) duty_reg[i] <= DUTY_W'(PARK_DUTY);
    end else begin
      counter <= counter_d;
      ServoPWM <= pwm_d;
      ActivePeriodFinished <= apf_d;
      DutyClampHit <= DutyClampHit | (sample && (lo || hi));
      for (int i = 0; i < NUM_SERVOS; i++)
        if (sample && int'(ServoNum) == i) duty_reg[i] <= duty_in;
    end
endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver: directed self-checking bench for servo_pwm_driver (PERIOD_CYCLES=100)
module tb_servo_pwm_driver;
`ifdef SERVO_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam int E60  = CLAMP ? 50 : 60;
  localparam int E200 = CLAMP ? 50 : 100;
  localparam int E0   = CLAMP ? 5 : 0;
  logic clk = 1'b0, rst, en;
  logic [1:0] sn;
  logic [20:0] duty;
  logic [3:0] pwm;
  logic apf, hit;
  int n_chk = 0, n_fail = 0;
  int hi_cnt [4];
  int rises [4];
  int apf_cnt, apf_pos, apf_total, idle_act;
  servo_pwm_driver #(.PERIOD_CYCLES(100), .NUM_SERVOS(4), .DUTY_W(21), .PARK_DUTY(10),
                     .MIN_DUTY(5), .MAX_DUTY(50)) dut (
    .clk(clk), .ResetServoModule(rst), .EnableServos(en), .ServoNum(sn),
    .ActiveServoDuty(duty), .ServoPWM(pwm), .ActivePeriodFinished(apf), .DutyClampHit(hit));
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Samples 100 cycles (one frame from counter=1 through the next counter=0),
  // optionally issuing a new command after sample chg_at.
  task automatic frame(input int chg_at, input logic [1:0] csn, input logic [20:0] cduty);
    logic [3:0] prev;
    prev = pwm;
    apf_cnt = 0;
    apf_pos = 0;
    for (int i = 0; i < 4; i++) begin
      hi_cnt[i] = 0;
      rises[i] = 0;
    end
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (pwm[i]) hi_cnt[i]++;
        if (pwm[i] && !prev[i]) rises[i]++;
      end
      prev = pwm;
      if (apf) begin
        apf_cnt++;
        apf_pos = k;
        apf_total++;
      end
      if (k == chg_at) begin
        sn = csn;
        duty = cduty;
      end
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; sn = 2'd0; duty = '0;
    repeat (2) @(negedge clk);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_apf", int'(apf), 0);
    chk("reset_hit", int'(hit), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_pwm", int'(pwm), 0);
    chk("idle_apf", int'(apf), 0);
    en = 1'b1; sn = 2'd2; duty = 21'd30;
    @(negedge clk);
    chk("enable_edge_pwm", int'(pwm), 0);
    apf_total = 0;
    frame(-1, 2'd0, '0);
    chk("f1_s2", hi_cnt[2], 30);
    chk("f1_s0", hi_cnt[0], 10);
    chk("f1_s1", hi_cnt[1], 10);
    chk("f1_s3", hi_cnt[3], 10);
    chk("f1_apf_cnt", apf_cnt, 1);
    chk("f1_apf_pos", apf_pos, 100);
    frame(40, 2'd2, 21'd60);
    chk("f2_s2_unchanged", hi_cnt[2], 30);
    chk("f2_s2_rises", rises[2], 1);
    chk("f2_apf_pos", apf_pos, 100);
    frame(50, 2'd1, 21'd20);
    chk("f3_s2_new", hi_cnt[2], E60);
    chk("f3_s2_rises", rises[2], 1);
    chk("f3_hit", int'(hit), int'(CLAMP));
    frame(50, 2'd0, 21'd40);
    chk("f4_s1", hi_cnt[1], 20);
    chk("f4_s0_hold", hi_cnt[0], 10);
    frame(-1, 2'd0, '0);
    chk("f5_s0", hi_cnt[0], 40);
    chk("f5_s1_hold", hi_cnt[1], 20);
    chk("f5_s2_hold", hi_cnt[2], E60);
    chk("f5_s3_hold", hi_cnt[3], 10);
    for (int f = 0; f < 76; f++) frame(-1, 2'd0, '0);
    chk("apf_total_81", apf_total, 81);
    chk("f81_s0", hi_cnt[0], 40);
    chk("f81_s1", hi_cnt[1], 20);
    repeat (15) @(negedge clk);
    chk("pre_disable_pwm", int'(pwm), 4'b0111);
    en = 1'b0;
    @(negedge clk);
    chk("disable_pwm", int'(pwm), 0);
    chk("disable_apf", int'(apf), 0);
    idle_act = 0;
    repeat (200) begin
      @(negedge clk);
      if (pwm != 4'b0 || apf) idle_act++;
    end
    chk("disabled_quiet", idle_act, 0);
    sn = 2'd2; duty = 21'd60; en = 1'b1;
    @(negedge clk);
    frame(-1, 2'd0, '0);
    chk("reen_s0", hi_cnt[0], 40);
    chk("reen_s1", hi_cnt[1], 20);
    chk("reen_s2", hi_cnt[2], E60);
    chk("reen_s3", hi_cnt[3], 10);
    chk("reen_apf_pos", apf_pos, 100);
    chk("reen_apf_cnt", apf_cnt, 1);
    repeat (5) @(negedge clk);
    chk("pre_reset_pwm", int'(pwm), 4'b1111);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_pwm", int'(pwm), 0);
    chk("async_reset_apf", int'(apf), 0);
    chk("async_reset_hit", int'(hit), 0);
    en = 1'b0; sn = 2'd3; duty = 21'd10;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);
    frame(50, 2'd1, 21'd200);
    chk("park_s0", hi_cnt[0], 10);
    chk("park_s1", hi_cnt[1], 10);
    chk("park_s2", hi_cnt[2], 10);
    chk("park_apf", apf_cnt, 1);
    frame(50, 2'd1, 21'd0);
    chk("big_duty_s1", hi_cnt[1], E200);
    chk("big_duty_hit", int'(hit), int'(CLAMP));
    frame(-1, 2'd0, '0);
    chk("zero_duty_s1", hi_cnt[1], E0);
    chk("zero_duty_hit_sticky", int'(hit), int'(CLAMP));
    repeat (99) @(negedge clk);
    en = 1'b0; sn = 2'd0; duty = 21'd7;
    @(negedge clk);
    chk("wrap_disable_apf", int'(apf), 0);
    chk("wrap_disable_pwm", int'(pwm), 0);
    sn = 2'd3; duty = 21'd10; en = 1'b1;
    @(negedge clk);
    frame(-1, 2'd0, '0);
    chk("wrap_disable_no_sample", hi_cnt[0], 10);
    chk("wrap_disable_apf_pos", apf_pos, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
- Servo pulse generator that answers the arm-sequencing controllers, including the IR/moisture probe sequencer.
- Accepts a target servo index (ServoNum) and a duty in clock cycles (ActiveServoDuty), and drives NUM_SERVOS PWM lines from one shared frame counter.
- Pulses ActivePeriodFinished once per frame so the sequencer can count dwell periods.
- Sits between the sequencers and the servo header pins.

Parameters:
- PERIOD_CYCLES, 2_000_000, frame length in clk cycles (20 ms at 100 MHz); must be greater than 2.
- NUM_SERVOS, 4, number of PWM outputs; ServoNum indexes 0..NUM_SERVOS-1.
- DUTY_W, 21, width of the duty and counter registers.
- PARK_DUTY, 100_000, duty loaded into every servo on reset.
- MIN_DUTY, 50_000, lower clamp (used only with SERVO_CLAMP_EN).
- MAX_DUTY, 250_000, upper clamp (used only with SERVO_CLAMP_EN).

Ports:
- clk  input  1  system clock
- ResetServoModule  input  1  asynchronous, active-high reset
- EnableServos  input  1  run frames when high; idle when low
- ServoNum  input  2  index of the servo the current command applies to
- ActiveServoDuty  input  DUTY_W  high time, in clk cycles, for the selected servo
- ServoPWM  output  NUM_SERVOS  one PWM line per servo
- ActivePeriodFinished  output  1  one-cycle pulse at each frame boundary
- DutyClampHit  output  1  sticky flag, set when a sampled duty was clamped

Behaviour:
- Reset (async, takes effect immediately):
  - counter = 0; running = 0.
  - duty_reg[i] = PARK_DUTY for all i.
  - ServoPWM = 0; ActivePeriodFinished = 0; DutyClampHit = 0.
- State: IDLE (running=0) and RUN (running=1).
- IDLE:
  - counter held at 0; ServoPWM = 0; no ActivePeriodFinished pulses.
  - On the first edge with EnableServos=1: move to RUN, counter stays 0.
  - On that same edge, sample: duty_reg[ServoNum] <= ActiveServoDuty.
- RUN:
  - counter increments every cycle and wraps from PERIOD_CYCLES-1 to 0.
  - On each wrap edge, sample duty_reg[ServoNum] <= ActiveServoDuty. Commands therefore take effect only at frame start; a mid-frame change never glitches the current pulse.
  - Non-selected servos keep their last duty and keep pulsing (position hold).
- ActivePeriodFinished:
  - Registered; high exactly one cycle, namely the cycle in which counter==0 following a wrap.
  - Never asserted in the first frame after leaving IDLE.
  - Dwell-count latency from a command = one full frame.
- ServoPWM[i]:
  - Registered, equal to (counter < duty_reg[i]) from the previous cycle.
  - This gives exactly duty_reg[i] high cycles per frame, starting 1 cycle after counter==0.
  - duty_reg = 0: line stays low.
  - duty_reg >= PERIOD_CYCLES: line stays high the whole frame (only possible without the clamp).
- ServoNum >= NUM_SERVOS: command ignored, no register written.
- EnableServos deasserted in RUN:
  - Next edge: IDLE, counter=0, ServoPWM=0.
  - An in-flight pulse is truncated; no ActivePeriodFinished is issued.
  - duty_reg values are retained.
- Simultaneous wrap and EnableServos falling: disable wins; no sample, no pulse.
- Reset mid-frame: all outputs drop to 0 asynchronously; duties return to PARK_DUTY.

Optional Feature:
- Macro: SERVO_CLAMP_EN.
- Defined:
  - Each sampled duty is saturated to [MIN_DUTY, MAX_DUTY] before writing duty_reg.
  - On any saturation, DutyClampHit is set and remains set until reset.
  - The PARK_DUTY reset value is not clamped.
- Undefined:
  - Duty is written unmodified.
  - DutyClampHit is tied to 0.

Test Plan (sim parameters: PERIOD_CYCLES=100, PARK_DUTY=10, MIN_DUTY=5, MAX_DUTY=50):
- Reset, then Enable=1 with ServoNum=2, duty=30 -> ServoPWM[2] high 30 cycles per frame; servos 0, 1, 3 high 10 cycles; ActivePeriodFinished first pulses 100 cycles after enable, then every 100 cycles.
- Change duty to 60 at counter=40 mid-frame -> current frame's pulse stays 30 cycles; next frame's pulse is 60 cycles; no glitch.
- Sequence ServoNum=1 duty=20, then ServoNum=0 duty=40 on successive frames -> servo 1 holds 20, servo 0 moves to 40; 81 ActivePeriodFinished pulses counted over 81 frames.
- Enable dropped at counter=15 while pulse is high -> all PWM outputs low on the next edge; no pulse issued; re-enable restarts at counter=0 with retained duties.
- Assert ResetServoModule between clock edges mid-pulse -> outputs go to 0 immediately (async); after release, duties are back at 10.
- With SERVO_CLAMP_EN defined: duty=200 gives a 50-cycle pulse and DutyClampHit=1 (sticky); duty=0 gives a 5-cycle pulse. Macro undefined: duty=200 holds the line high the whole frame and DutyClampHit stays 0.
